// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit: next-PC selects, FSM
// encoding and the default reset vector.
package ifu_pkg;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_J   = 2'b01;
   localparam logic [1:0] PC_JR  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } ifu_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/ifu_fetch_unit_npc_calc.sv
// Combinational next-PC selection: sequential, taken beq, j/jal and jr.
// Jump/jr selects win over the branch condition.
module npc_calc
   import ifu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [31:0]       ir,
   input  logic              nPC_sel,
   input  logic              zero,
   input  logic [1:0]        pc_sel,
   input  logic [31:0]       rs_data,
   output logic [ADDR_W-1:0] npc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              misalign
);

   logic [ADDR_W-1:0] br_offset;
   logic              unused_opcode;

   assign unused_opcode = ^ir[31:26];

   assign pc_plus4  = pc + ADDR_W'(4);
   assign br_offset = {{(ADDR_W-18){ir[15]}}, ir[15:0], 2'b00};
   assign misalign  = (rs_data[1:0] != 2'b00);

   always_comb begin
      npc = pc_plus4;
      if (pc_sel == PC_J) begin
         npc = {pc_plus4[ADDR_W-1:28], ir[25:0], 2'b00};
      end else if (pc_sel == PC_JR) begin
         // Low bits are forced to zero; the misalignment is reported, not trapped.
         npc = {rs_data[ADDR_W-1:2], 2'b00};
      end else if (pc_sel == PC_SEQ && nPC_sel && zero) begin
         npc = pc_plus4 + br_offset;
      end
   end

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, runs the imem req/ack handshake and
// commits the next PC when the datapath signals exec_done.
module ifu_fetch_unit
   import ifu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   input  logic              exec_done,
   input  logic              nPC_sel,
   input  logic              zero,
   input  logic [1:0]        pc_sel,
   input  logic [31:0]       rs_data,
   output logic              jr_misalign
);

   ifu_state_e        state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [31:0]       ir_q;
   logic              req_q;
   logic              valid_q;
   logic              misalign_q;
   logic              rs_misalign;

   npc_calc #(
      .ADDR_W (ADDR_W)
   ) u_npc_calc (
      .pc       (pc_q),
      .ir       (ir_q),
      .nPC_sel  (nPC_sel),
      .zero     (zero),
      .pc_sel   (pc_sel),
      .rs_data  (rs_data),
      .npc      (pc_d),
      .pc_plus4 (pc_plus4),
      .misalign (rs_misalign)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= 32'h0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_FETCH;
               req_q   <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  ir_q    <= imem_rdata;
                  state_q <= ST_EXEC;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            ST_EXEC: begin
               // Decoder selects are only meaningful on this commit edge.
               if (exec_done) begin
                  pc_q       <= pc_d;
                  state_q    <= ST_FETCH;
                  req_q      <= 1'b1;
                  valid_q    <= 1'b0;
                  misalign_q <= (pc_sel == PC_JR) && rs_misalign;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = ir_q;
   assign instr_valid = valid_q;
   assign jr_misalign = misalign_q;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Randomised transaction-level bench for ifu_fetch_unit with a next-PC
// reference model computed from the instruction-set rules.
module tb_ifu_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        exec_done;
   logic        nPC_sel;
   logic        zero;
   logic [1:0]  pc_sel;
   logic [31:0] rs_data;
   logic        jr_misalign;

   int          total;
   int          bad;
   logic [31:0] exp_pc;

   ifu_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .exec_done   (exec_done),
      .nPC_sel     (nPC_sel),
      .zero        (zero),
      .pc_sel      (pc_sel),
      .rs_data     (rs_data),
      .jr_misalign (jr_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference next PC, straight from the instruction semantics.
   function automatic logic [31:0] model_npc(input logic [31:0] cur_pc, input logic [31:0] ir,
                                             input logic [1:0] psel, input logic nsel,
                                             input logic z, input logic [31:0] rs);
      logic [31:0]        link;
      logic signed [15:0] imm;
      int                 off;
      link = cur_pc + 32'd4;
      imm  = ir[15:0];
      off  = imm;
      if (psel == 2'b01) return (link & 32'hF000_0000) | ({6'b0, ir[25:0]} << 2);
      if (psel == 2'b10) return rs & 32'hFFFF_FFFC;
      if (psel == 2'b00 && nsel && z) return link + 32'(off * 4);
      return link;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      imem_ack = 1'b0;
      exec_done = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      exp_pc = 32'h0000_3000;
   endtask

   task automatic run_instr(input logic [31:0] word, input int waits, input int hold,
                            input logic [1:0] psel, input logic nsel, input logic z,
                            input logic [31:0] rs);
      int          n;
      logic [31:0] nxt;
      logic        exp_mis;
      n = 0;
      while (!imem_req && n < 8) begin
         tick();
         n++;
      end
      check("req_seen", {31'b0, imem_req}, 32'd1);
      check("fetch_addr", imem_addr, exp_pc);
      check("valid_in_fetch", {31'b0, instr_valid}, 32'd0);
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      for (int i = 0; i < waits; i++) begin
         tick();
         check("req_hold", {31'b0, imem_req}, 32'd1);
         check("addr_hold", imem_addr, exp_pc);
      end
      imem_ack = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      check("ir_load", instr, word);
      check("valid_exec", {31'b0, instr_valid}, 32'd1);
      check("req_exec", {31'b0, imem_req}, 32'd0);
      check("pc_exec", pc, exp_pc);
      check("pc_plus4", pc_plus4, exp_pc + 32'd4);
      exec_done = 1'b0;
      for (int i = 0; i < hold; i++) begin
         pc_sel = 2'($urandom);
         nPC_sel = 1'($urandom);
         zero = 1'($urandom);
         rs_data = $urandom;
         tick();
         check("ir_frozen", instr, word);
         check("pc_frozen", pc, exp_pc);
         check("valid_held", {31'b0, instr_valid}, 32'd1);
      end
      pc_sel = psel;
      nPC_sel = nsel;
      zero = z;
      rs_data = rs;
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      imem_ack = 1'b0;
      nxt = model_npc(exp_pc, word, psel, nsel, z, rs);
      exp_mis = (psel == 2'b10) && (rs[1:0] != 2'b00);
      check("npc", imem_addr, nxt);
      check("jr_misalign", {31'b0, jr_misalign}, {31'b0, exp_mis});
      check("valid_drop", {31'b0, instr_valid}, 32'd0);
      exp_pc = nxt;
      if (exp_mis) begin
         tick();
         check("jr_pulse_end", {31'b0, jr_misalign}, 32'd0);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      exec_done = 1'b0;
      nPC_sel = 1'b0;
      zero = 1'b0;
      pc_sel = 2'b00;
      rs_data = 32'h0;
      #3;
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_pc", pc, 32'h0000_3000);
      check("rst_ir", instr, 32'h0);
      check("rst_misalign", {31'b0, jr_misalign}, 32'd0);

      // Ack and exec_done tied high: one instruction every two cycles.
      tick();
      imem_ack = 1'b1;
      exec_done = 1'b1;
      reset = 1'b0;
      check("idle_req", {31'b0, imem_req}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("tied_valid", {31'b0, instr_valid}, {31'b0, 1'(i % 2)});
         check("tied_req", {31'b0, imem_req}, {31'b0, 1'((i + 1) % 2)});
         check("tied_addr", imem_addr, 32'h0000_3000 + 32'(4 * (i / 2)));
      end

      do_reset();
      run_instr(32'h1000_FFFF, 0, 0, 2'b00, 1'b1, 1'b1, 32'h0);
      run_instr(32'h1000_FFFF, 0, 0, 2'b00, 1'b1, 1'b0, 32'h0);
      run_instr(32'h0800_0C03, 0, 0, 2'b01, 1'b1, 1'b1, 32'h0);
      run_instr(32'h0000_0008, 0, 0, 2'b10, 1'b0, 1'b0, 32'h0000_3011);
      run_instr($urandom, 3, 5, 2'b00, 1'b0, 1'b0, 32'h0);
      run_instr(32'h0000_0008, 1, 0, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC);
      run_instr($urandom, 0, 1, 2'b11, 1'b1, 1'b1, 32'h0);

      // Reset while waiting for ack at 0x3008; the concurrent ack must be lost.
      do_reset();
      run_instr($urandom, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0);
      run_instr($urandom, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0);
      tick();
      check("pre_rst_addr", imem_addr, 32'h0000_3008);
      #2;
      imem_ack = 1'b1;
      reset = 1'b1;
      #1;
      check("fetch_rst_req", {31'b0, imem_req}, 32'd0);
      check("fetch_rst_pc", pc, 32'h0000_3000);
      tick();
      #3;
      reset = 1'b0;
      imem_ack = 1'b0;
      exp_pc = 32'h0000_3000;
      check("post_rst_idle", {31'b0, imem_req}, 32'd0);
      check("post_rst_ir", instr, 32'h0);

      // Reset while in EXEC: no PC commit, valid drops at once.
      run_instr($urandom, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0);
      tick();
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      exec_done = 1'b1;
      check("exec_before_rst", {31'b0, instr_valid}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("exec_rst_valid", {31'b0, instr_valid}, 32'd0);
      check("exec_rst_pc", pc, 32'h0000_3000);
      tick();
      exec_done = 1'b0;
      reset = 1'b0;
      exp_pc = 32'h0000_3000;

      for (int k = 0; k < 40; k++) begin
         run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   2'($urandom), 1'($urandom), 1'($urandom), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
